// File: rtl/calculo_distancias.sv
// Distance engine: buffers one sample and computes its L1 distance to 10 ROM templates.
// Define SQUARED_DIST_EN to accumulate squared differences instead (one extra pipe stage).
module calculo_distancias #(
  parameter int unsigned N_FEAT = 64,
  parameter int unsigned FEAT_W = 8,
  parameter int unsigned ADDR_W = $clog2(10 * N_FEAT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  input  logic [FEAT_W-1:0]     feat_data,
  input  logic                  feat_last,
  output logic [ADDR_W-1:0]     tmpl_addr,
  input  logic [FEAT_W-1:0]     tmpl_data,
  output logic [9:0][15:0]      v_diferenca,
  output logic                  flag,
  output logic                  busy
);

  localparam int unsigned NTmpl = 10;
  localparam int unsigned NAddr = NTmpl * N_FEAT;
  localparam int unsigned JIdxW = $clog2(N_FEAT);
  localparam int unsigned CntJW = $clog2(N_FEAT + 1);
`ifdef SQUARED_DIST_EN
  localparam int unsigned PipeLat = 3;
  localparam int unsigned DW      = 2 * FEAT_W + 2;
`else
  localparam int unsigned PipeLat = 2;
  localparam int unsigned DW      = FEAT_W;
`endif
  localparam int unsigned CalcLen = NAddr + PipeLat;
  localparam int unsigned CntW    = $clog2(CalcLen);
  localparam int unsigned SumW    = ((DW > 16) ? DW : 16) + 1;

  typedef enum logic [1:0] {StLoad, StCalc, StWrite, StDone} state_e;

  state_e state_q, state_d;

  logic                  xfer;
  logic                  issue;
  logic [CntW-1:0]       calc_cnt_q, calc_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [JIdxW-1:0]      j0_q, j0_d;
  logic [3:0]            k0_q, k0_d;

  logic [FEAT_W-1:0]     buf_q [N_FEAT];
  logic [CntJW-1:0]      fcnt_q;

  // Stage 1: ROM data for the address issued last cycle is on tmpl_data.
  logic                  s1_valid_q;
  logic [JIdxW-1:0]      s1_j_q;
  logic [3:0]            s1_k_q;
  logic signed [FEAT_W:0] diff;

  // Stage 2: per-feature difference registered.
  logic                  s2_valid_q;
  logic                  s2_first_q;
  logic [3:0]            s2_k_q;

  // Final stage feeding the accumulators.
  logic                  fin_valid;
  logic                  fin_first;
  logic [3:0]            fin_k;
  logic [DW-1:0]         fin_d;

  logic [15:0]           acc_q [NTmpl];
  logic [15:0]           acc_d [NTmpl];
  logic [SumW-1:0]       sum;
  logic [9:0][15:0]      v_dif_q;

  assign xfer  = feat_valid & feat_ready;
  assign issue = (state_q == StCalc) && (calc_cnt_q < CntW'(NAddr));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (xfer && feat_last) state_d = StCalc;
      StCalc:  if (calc_cnt_q == CntW'(CalcLen - 1)) state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    feat_ready = 1'b0;
    busy       = 1'b0;
    flag       = 1'b0;
    unique case (state_q)
      StLoad:  feat_ready = 1'b1;
      StCalc:  busy = 1'b1;
      StWrite: busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        flag = 1'b1;
      end
      default: feat_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample buffer: cleared after each sample so short samples read zeros.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n || state_q == StWrite) begin
      for (int i = 0; i < N_FEAT; i++) begin
        buf_q[i] <= '0;
      end
      fcnt_q <= '0;
    end else if (xfer && fcnt_q < CntJW'(N_FEAT)) begin
      buf_q[fcnt_q[JIdxW-1:0]] <= feat_data;
      fcnt_q                   <= fcnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address sequencer: addr = k*N_FEAT + j, tracked as separate j/k counters.
  // ---------------------------------------------------------------------------
  always_comb begin
    calc_cnt_d = '0;
    addr_d     = '0;
    j0_d       = '0;
    k0_d       = '0;
    if (state_q == StCalc) begin
      calc_cnt_d = calc_cnt_q + 1'b1;
      addr_d     = addr_q;
      j0_d       = j0_q;
      k0_d       = k0_q;
      if (issue && addr_q != ADDR_W'(NAddr - 1)) begin
        addr_d = addr_q + 1'b1;
        if (j0_q == JIdxW'(N_FEAT - 1)) begin
          j0_d = '0;
          k0_d = k0_q + 4'd1;
        end else begin
          j0_d = j0_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      calc_cnt_q <= '0;
      addr_q     <= '0;
      j0_q       <= '0;
      k0_q       <= '0;
    end else begin
      calc_cnt_q <= calc_cnt_d;
      addr_q     <= addr_d;
      j0_q       <= j0_d;
      k0_q       <= k0_d;
    end
  end

  assign tmpl_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Difference pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    diff = $signed({1'b0, buf_q[s1_j_q]}) - $signed({1'b0, tmpl_data});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_j_q     <= '0;
      s1_k_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_k_q     <= '0;
    end else begin
      s1_valid_q <= issue;
      s1_j_q     <= j0_q;
      s1_k_q     <= k0_q;
      s2_valid_q <= s1_valid_q;
      s2_first_q <= (s1_j_q == '0);
      s2_k_q     <= s1_k_q;
    end
  end

`ifdef SQUARED_DIST_EN
  logic signed [FEAT_W:0] s2_diff_q;
  logic signed [DW-1:0]   diff_ext;
  logic signed [DW-1:0]   sq;
  logic                   s3_valid_q;
  logic                   s3_first_q;
  logic [3:0]             s3_k_q;
  logic [DW-1:0]          s3_d_q;

  always_comb begin
    diff_ext = DW'(s2_diff_q);
    sq       = diff_ext * diff_ext;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_diff_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_first_q <= 1'b0;
      s3_k_q     <= '0;
      s3_d_q     <= '0;
    end else begin
      s2_diff_q  <= diff;
      s3_valid_q <= s2_valid_q;
      s3_first_q <= s2_first_q;
      s3_k_q     <= s2_k_q;
      s3_d_q     <= sq;
    end
  end

  assign fin_valid = s3_valid_q;
  assign fin_first = s3_first_q;
  assign fin_k     = s3_k_q;
  assign fin_d     = s3_d_q;
`else
  logic [DW-1:0] absd;
  logic [DW-1:0] s2_d_q;

  always_comb begin
    absd = diff[FEAT_W] ? FEAT_W'(-diff) : FEAT_W'(diff);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_d_q <= '0;
    end else begin
      s2_d_q <= absd;
    end
  end

  assign fin_valid = s2_valid_q;
  assign fin_first = s2_first_q;
  assign fin_k     = s2_k_q;
  assign fin_d     = s2_d_q;
`endif

  // ---------------------------------------------------------------------------
  // Saturating accumulators; the j=0 term restarts the template's sum.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    for (int k = 0; k < NTmpl; k++) begin
      if (fin_valid && fin_k == 4'(k)) begin
        sum      = (fin_first ? SumW'(0) : SumW'(acc_q[k])) + SumW'(fin_d);
        acc_d[k] = (sum > SumW'(16'hFFFF)) ? 16'hFFFF : sum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NTmpl; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end

  // Results are loaded all at once so the consumer never sees a mixed set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_dif_q <= '0;
    end else if (state_q == StWrite) begin
      for (int k = 0; k < NTmpl; k++) begin
        v_dif_q[k] <= acc_q[k];
      end
    end
  end

  assign v_diferenca = v_dif_q;

endmodule

// File: tb/tb_calculo_distancias.sv
// Self-checking bench for calculo_distancias: random and directed samples vs a distance model.
module tb_calculo_distancias;

  localparam int NF = 64;
  localparam int NA = 10 * NF;
  localparam int NS = 300;
`ifdef SQUARED_DIST_EN
  localparam int LatX = 5;
`else
  localparam int LatX = 4;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            feat_valid, feat_ready, feat_last, flag, busy;
  logic [7:0]      feat_data, tmpl_data;
  logic [9:0]      tmpl_addr;
  logic [9:0][15:0] v_diferenca;

  logic            feat_valid_s, feat_ready_s, feat_last_s, flag_s, busy_s;
  logic [7:0]      feat_data_s, tmpl_data_s;
  logic [11:0]     tmpl_addr_s;
  logic [9:0][15:0] v_dif_s;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int xfer_cnt = 0;
  int last_cyc = 0;

  logic [7:0]      rom [NA];
  int unsigned     stream [128];
  longint unsigned expv [10];

  calculo_distancias u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .feat_last  (feat_last),
    .tmpl_addr  (tmpl_addr),
    .tmpl_data  (tmpl_data),
    .v_diferenca(v_diferenca),
    .flag       (flag),
    .busy       (busy)
  );

  calculo_distancias #(.N_FEAT(NS)) u_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .feat_valid (feat_valid_s),
    .feat_ready (feat_ready_s),
    .feat_data  (feat_data_s),
    .feat_last  (feat_last_s),
    .tmpl_addr  (tmpl_addr_s),
    .tmpl_data  (tmpl_data_s),
    .v_diferenca(v_dif_s),
    .flag       (flag_s),
    .busy       (busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tmpl_data <= (tmpl_addr < 10'(NA)) ? rom[tmpl_addr] : 8'h00;
  always @(posedge clk) tmpl_data_s <= (tmpl_addr_s < 12'(10 * NS)) ? 8'hFF : 8'h00;
  always @(negedge clk) if (flag) flag_cnt <= flag_cnt + 1;
  always @(posedge clk) if (feat_valid && feat_ready) xfer_cnt <= xfer_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < NA; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_stream_random(input int len);
    for (int i = 0; i < len; i++) stream[i] = $urandom_range(0, 255);
  endtask

  // Distance of the stored sample (first NF words, zero-padded) to each template.
  task automatic build_expect(input int len);
    longint unsigned s;
    longint a, b, d;
    for (int k = 0; k < 10; k++) begin
      s = 0;
      for (int j = 0; j < NF; j++) begin
        a = (j < len) ? longint'(stream[j]) : 0;
        b = longint'(rom[k * NF + j]);
        d = (a > b) ? a - b : b - a;
`ifdef SQUARED_DIST_EN
        d = d * d;
`endif
        s += longint'(d);
      end
      expv[k] = (s > 65535) ? 65535 : s;
    end
  endtask

  task automatic send_sample(input int len);
    int w;
    for (int i = 0; i < len; i++) begin
      w = 0;
      while (!feat_ready && w < 2000) begin
        @(posedge clk);
        #1;
        w++;
      end
      feat_valid = 1'b1;
      feat_data  = stream[i][7:0];
      feat_last  = (i == len - 1);
      if (i == len - 1) last_cyc = cyc;
      @(posedge clk);
      #1;
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  task automatic run_sample(input string tag, input int len, input bit hold,
                            input int unsigned next0);
    int fc0, xc0, n;
    build_expect(len);
    send_sample(len);
    if (hold) begin
      feat_valid = 1'b1;
      feat_data  = next0[7:0];
      feat_last  = 1'b0;
    end
    fc0 = flag_cnt;
    xc0 = xfer_cnt;
    check({tag, "_busy_calc"}, 64'(busy), 1);
    check({tag, "_ready_calc"}, 64'(feat_ready), 0);
    n = 0;
    while (!flag && n < NA + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_flag_seen"}, 64'(flag), 1);
    check({tag, "_latency"}, 64'(cyc - last_cyc), 64'(NA + LatX));
    check({tag, "_busy_done"}, 64'(busy), 1);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_vdif[%0d]", tag, k), 64'(v_diferenca[k]), expv[k]);
    if (hold) check({tag, "_xfer_while_busy"}, 64'(xfer_cnt - xc0), 0);
    @(posedge clk);
    #1;
    check({tag, "_flag_pulses"}, 64'(flag_cnt - fc0), 1);
    check({tag, "_flag_low"}, 64'(flag), 0);
    check({tag, "_ready_after"}, 64'(feat_ready), 1);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_hold[%0d]", tag, k), 64'(v_diferenca[k]), expv[k]);
  endtask

  initial begin
    int n, fc0, c0;
    int unsigned nxt;

    reset_n      = 1'b0;
    feat_valid   = 1'b0;
    feat_data    = '0;
    feat_last    = 1'b0;
    feat_valid_s = 1'b0;
    feat_data_s  = '0;
    feat_last_s  = 1'b0;
    for (int i = 0; i < NA; i++) rom[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_flag", 64'(flag), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(feat_ready), 1);
    check("rst_addr", 64'(tmpl_addr), 0);
    for (int k = 0; k < 10; k++) check($sformatf("rst_vdif[%0d]", k), 64'(v_diferenca[k]), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Saturation: 300 zero features vs templates of 255 (single word, rest zero-filled)
    feat_valid_s = 1'b1;
    feat_data_s  = 8'd0;
    feat_last_s  = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    feat_valid_s = 1'b0;
    feat_last_s  = 1'b0;
    n = 0;
    while (!flag_s && n < 10 * NS + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sat_flag_seen", 64'(flag_s), 1);
    check("sat_latency", 64'(cyc - c0), 64'(10 * NS + LatX));
    for (int k = 0; k < 10; k++) check($sformatf("sat_vdif[%0d]", k), 64'(v_dif_s[k]), 65535);
    @(posedge clk);
    #1;

    // Nominal: features 100, template k all 100+10k
    for (int i = 0; i < 64; i++) stream[i] = 100;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < NF; j++) rom[k * NF + j] = 8'(100 + 10 * k);
    run_sample("nominal", 64, 1'b0, 0);

    // Short sample: 10 words of 50, templates zero
    for (int i = 0; i < 10; i++) stream[i] = 50;
    for (int i = 0; i < NA; i++) rom[i] = '0;
    run_sample("short", 10, 1'b0, 0);

    // Random full, random short, and over-length samples
    fill_rom_random();
    fill_stream_random(64);
    run_sample("rand_full", 64, 1'b0, 0);
    n = $urandom_range(1, 63);
    fill_stream_random(n);
    run_sample("rand_short", n, 1'b0, 0);
    fill_rom_random();
    fill_stream_random(100);
    run_sample("rand_long", 100, 1'b0, 0);

    // Reset mid-CALC at address 200
    fill_rom_random();
    fill_stream_random(64);
    fc0 = flag_cnt;
    send_sample(64);
    n = 0;
    while (tmpl_addr != 10'd200 && n < NA) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_addr200", 64'(tmpl_addr), 200);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("abort_flag", 64'(flag), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_ready", 64'(feat_ready), 1);
    check("abort_addr", 64'(tmpl_addr), 0);
    for (int k = 0; k < 10; k++) check($sformatf("abort_vdif[%0d]", k), 64'(v_diferenca[k]), 0);
    repeat (NA + 10) @(posedge clk);
    #1;
    check("abort_no_flag", 64'(flag_cnt - fc0), 0);
    run_sample("post_abort", 64, 1'b0, 0);

    // Back-to-back with feat_valid held high through CALC/WRITE/DONE
    fill_rom_random();
    fill_stream_random(64);
    nxt = $urandom_range(0, 255);
    run_sample("b2b_first", 64, 1'b1, nxt);
    fill_stream_random(64);
    stream[0] = nxt;
    run_sample("b2b_second", 64, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
